board_io_ctrl: RTL
==================

# board_io_ctrl

Parametrised board-support block between raw board pins and the tinyQV core on the Nano-class FPGA tops. Synchronises and debounces N push-buttons, derives a stretched core reset from them, and drives M LEDs, each selectable at run time between direct, activity-stretched, heartbeat and off. It replaces raw button-OR reset, direct LED-to-UART wiring and the ad-hoc blink counter with one reusable, clean-clock-domain unit on the core clock.

## Interface
- NUM_BTN, 2: number of buttons (1..8)
- NUM_LED, 6: number of LEDs (1..16)
- DEBOUNCE_CYC, 64000: consecutive stable cycles required to accept a button change (≥2)
- STRETCH_CYC, 3200000: LED on-time after the last activity strobe (≥1)
- HEARTBEAT_HALF_CYC, 32000000: heartbeat half-period in cycles (≥1)
- RST_HOLD_CYC, 1024: core reset hold after all buttons released (≥1)
- LED_ACTIVE_LOW, 1: 1 = LED pin low means lit
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- btn_i  in  NUM_BTN  raw buttons, asynchronous, 1 = pressed
- btn_level_o  out  NUM_BTN  debounced button level
- btn_press_o  out  NUM_BTN  one-cycle pulse on debounced 0→1
- core_rst_n_o  out  1  active-low reset for the core
- act_i  in  NUM_LED  per-LED activity level/strobe (synchronous to clk)
- led_mode_i  in  2*NUM_LED  per-LED mode, bits [2i+1:2i]: 00 direct, 01 stretch, 10 heartbeat, 11 off
- led_o  out  NUM_LED  LED pins, polarity per LED_ACTIVE_LOW

## Operation
- Sync: two flops per btn_i bit, reset 0.
- Debounce, per button: counter of width clog2(DEBOUNCE_CYC). Synced value equal to btn_level_o → counter cleared. Different → counter increments; at DEBOUNCE_CYC-1 btn_level_o takes the synced value, counter clears. Any glitch back to the current level restarts the count.
- btn_press_o: registered, high exactly the cycle btn_level_o first reads 1; never on release.
- Reset FSM, states ASSERT, COUNT, RUN:
  - ASSERT: core_rst_n_o=0; leave to COUNT (hold counter=0) when all btn_level_o=0.
  - COUNT: core_rst_n_o=0; counter increments; at RST_HOLD_CYC-1 → RUN.
  - RUN: core_rst_n_o=1.
  - Any btn_level_o=1 in COUNT or RUN → ASSERT next cycle (counter cleared).
  - rst_n low → COUNT, counter 0; power-up therefore gives RST_HOLD_CYC cycles of core reset.
- Stretch counter, per LED, runs in every mode: act_i=1 loads STRETCH_CYC; else decrements to 0 and holds. Retrigger reloads.
- Heartbeat: one shared counter 0..HEARTBEAT_HALF_CYC-1, toggles hb at wrap; hb resets to 0.
- LED lit: direct = act_i; stretch = stretch counter ≠0 after update (i.e. act_i or counter>1); heartbeat = hb; off = 0. led_o registered = lit XOR LED_ACTIVE_LOW.
- Mode change applies next cycle; no counter reset on mode change.

## Timing
- Reset values: btn_level_o=0, btn_press_o=0, core_rst_n_o=0, led_o={NUM_LED{LED_ACTIVE_LOW}} (all unlit), all counters 0.
- btn_i edge stable at cycle t → btn_level_o changes at t+2+DEBOUNCE_CYC; btn_press_o pulses same cycle.
- core_rst_n_o falls 1 cycle after any btn_level_o rises; rises exactly RST_HOLD_CYC+1 cycles after all btn_level_o are 0.
- Direct: act_i at cycle t → led_o lit at t+1.
- Stretch: act_i high only at cycle t → lit t+1 through t+STRETCH_CYC inclusive, unlit at t+STRETCH_CYC+1.
- Heartbeat: led_o toggles every HEARTBEAT_HALF_CYC cycles; first lit HEARTBEAT_HALF_CYC+1 cycles after reset release.
- rst_n assertion mid-operation: all outputs return to reset values asynchronously.

## Test plan
Use DEBOUNCE_CYC=4, STRETCH_CYC=8, HEARTBEAT_HALF_CYC=5, RST_HOLD_CYC=16, LED_ACTIVE_LOW=1.
- Release rst_n, buttons idle → core_rst_n_o low for 16 cycles then 1; led_o=6'h3F throughout with modes 11.
- Press btn 0 cleanly at t → btn_level_o[0]=1 and btn_press_o[0] one-cycle pulse at t+6; core_rst_n_o=0 at t+7; release → core_rst_n_o=1 17 cycles after level falls.
- Bounce btn 1 (3 high, 1 low, 3 high cycles) → no btn_level_o change, no pulse; then hold 6 → accepted.
- LED 2 mode 01, single act_i[2] pulse at t → led_o[2]=0 for t+1..t+8, 1 at t+9; retrigger at t+4 → lit to t+12.
- LED 0 mode 10 → led_o[0] toggles period 10 cycles; switch to 00 with act_i[0]=1 → led_o[0]=0 next cycle.
- Press during COUNT (cycle 10 of hold) → back to ASSERT, full 16-cycle hold restarts after release; assert rst_n mid-stretch → led_o=6'h3F immediately.

Source files
------------

// File: rtl/board_io_ctrl.sv
// board_io_ctrl: board-support block between raw board pins and the core.
//   - Synchronises and debounces NUM_BTN push-buttons.
//   - Derives a stretched, active-low core reset from the debounced buttons.
//   - Drives NUM_LED LEDs, each selectable between direct, activity-stretched,
//     heartbeat and off.
// Ports:
//   clk           core clock
//   rst_n         asynchronous active-low reset
//   btn_i         raw asynchronous buttons, 1 = pressed
//   btn_level_o   debounced button level
//   btn_press_o   one-cycle pulse on debounced 0->1
//   core_rst_n_o  active-low reset for the core
//   act_i         per-LED activity level/strobe (synchronous to clk)
//   led_mode_i    per-LED mode, bits [2i+1:2i]: 00 direct, 01 stretch, 10 heartbeat, 11 off
//   led_o         LED pins, polarity set by LED_ACTIVE_LOW
module board_io_ctrl #(
  parameter int unsigned NUM_BTN            = 2,
  parameter int unsigned NUM_LED            = 6,
  parameter int unsigned DEBOUNCE_CYC       = 64000,
  parameter int unsigned STRETCH_CYC        = 3200000,
  parameter int unsigned HEARTBEAT_HALF_CYC = 32000000,
  parameter int unsigned RST_HOLD_CYC       = 1024,
  parameter int unsigned LED_ACTIVE_LOW     = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_BTN-1:0]     btn_i,
  output logic [NUM_BTN-1:0]     btn_level_o,
  output logic [NUM_BTN-1:0]     btn_press_o,
  output logic                   core_rst_n_o,
  input  logic [NUM_LED-1:0]     act_i,
  input  logic [2*NUM_LED-1:0]   led_mode_i,
  output logic [NUM_LED-1:0]     led_o
);

  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYC);
  localparam int unsigned STR_W = $clog2(STRETCH_CYC + 1);
  localparam int unsigned HB_W  = (HEARTBEAT_HALF_CYC > 1) ? $clog2(HEARTBEAT_HALF_CYC) : 1;
  localparam int unsigned RH_W  = (RST_HOLD_CYC > 1) ? $clog2(RST_HOLD_CYC) : 1;

  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [STR_W-1:0] STR_LOAD  = STR_W'(STRETCH_CYC);
  localparam logic [HB_W-1:0]  HB_LAST   = HB_W'(HEARTBEAT_HALF_CYC - 1);
  localparam logic [RH_W-1:0]  HOLD_LAST = RH_W'(RST_HOLD_CYC - 1);
  localparam logic             POL       = (LED_ACTIVE_LOW != 0);

  // ---------------- button sync + debounce ----------------
  logic [NUM_BTN-1:0] sync1, sync2;
  logic [DB_W-1:0]    db_cnt [NUM_BTN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1       <= '0;
      sync2       <= '0;
      btn_level_o <= '0;
      btn_press_o <= '0;
      for (int unsigned i = 0; i < NUM_BTN; i++) db_cnt[i] <= '0;
    end else begin
      sync1       <= btn_i;
      sync2       <= sync1;
      btn_press_o <= '0;
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        if (sync2[i] == btn_level_o[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          btn_level_o[i] <= sync2[i];
          // press pulse coincides with the level turning 1, never on release
          btn_press_o[i] <= sync2[i];
          db_cnt[i]      <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // ---------------- core reset sequencer ----------------
  typedef enum logic [1:0] {ST_ASSERT, ST_COUNT, ST_RUN} rst_state_t;
  rst_state_t      rst_state;
  logic [RH_W-1:0] hold_cnt;

  // Async reset lands in COUNT so power-up yields exactly RST_HOLD_CYC cycles of core reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_state    <= ST_COUNT;
      hold_cnt     <= '0;
      core_rst_n_o <= 1'b0;
    end else if (|btn_level_o) begin
      rst_state    <= ST_ASSERT;
      hold_cnt     <= '0;
      core_rst_n_o <= 1'b0;
    end else begin
      case (rst_state)
        ST_ASSERT: begin
          rst_state    <= ST_COUNT;
          hold_cnt     <= '0;
          core_rst_n_o <= 1'b0;
        end
        ST_COUNT: begin
          if (hold_cnt == HOLD_LAST) begin
            rst_state    <= ST_RUN;
            hold_cnt     <= '0;
            core_rst_n_o <= 1'b1;
          end else begin
            hold_cnt     <= hold_cnt + 1'b1;
            core_rst_n_o <= 1'b0;
          end
        end
        ST_RUN: begin
          core_rst_n_o <= 1'b1;
        end
        default: begin
          rst_state    <= ST_ASSERT;
          hold_cnt     <= '0;
          core_rst_n_o <= 1'b0;
        end
      endcase
    end
  end

  // ---------------- LEDs ----------------
  logic [STR_W-1:0]   str_cnt  [NUM_LED];
  logic [STR_W-1:0]   str_next [NUM_LED];
  logic [HB_W-1:0]    hb_cnt;
  logic               hb;
  logic [NUM_LED-1:0] lit;

  // Stretch counters run regardless of mode; "lit" in stretch mode looks at the
  // post-update count so a single strobe lights exactly STRETCH_CYC cycles.
  always_comb begin
    lit = '0;
    for (int unsigned i = 0; i < NUM_LED; i++) begin
      str_next[i] = str_cnt[i];
      if (act_i[i])                str_next[i] = STR_LOAD;
      else if (str_cnt[i] != '0)   str_next[i] = str_cnt[i] - 1'b1;
      case (led_mode_i[2*i +: 2])
        2'b00:   lit[i] = act_i[i];
        2'b01:   lit[i] = (str_next[i] != '0);
        2'b10:   lit[i] = hb;
        default: lit[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_cnt <= '0;
      hb     <= 1'b0;
      led_o  <= {NUM_LED{POL}};
      for (int unsigned i = 0; i < NUM_LED; i++) str_cnt[i] <= '0;
    end else begin
      if (hb_cnt == HB_LAST) begin
        hb_cnt <= '0;
        hb     <= ~hb;
      end else begin
        hb_cnt <= hb_cnt + 1'b1;
      end
      for (int unsigned i = 0; i < NUM_LED; i++) str_cnt[i] <= str_next[i];
      led_o <= lit ^ {NUM_LED{POL}};
    end
  end

endmodule
